// File: rtl/max7219_pkg.sv
// Shared MAX7219 register map, sequencer state type and command-list index layout.
package max7219_pkg;

    localparam logic [3:0] ADDR_NOOP       = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1     = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2     = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3     = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4     = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5     = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6     = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
    localparam logic [3:0] ADDR_DECODE     = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
    localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
    localparam logic [3:0] ADDR_TEST       = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } seq_state_t;

    // One flat list: 0..3 fixed setup, 4 intensity, 5.. digits. Each sequence is a start/end window.
    localparam logic [3:0] CMD_IDX_FIRST       = 4'd0;
    localparam logic [3:0] CMD_IDX_INTENSITY   = 4'd4;
    localparam logic [3:0] CMD_IDX_FIRST_DIGIT = 4'd5;

    function automatic logic [3:0] last_cmd_idx(input int unsigned num_digits);
        return 4'(4 + num_digits);
    endfunction

endpackage

// File: rtl/max7219_cmd_rom.sv
// Combinational command list: maps a command index plus snapshot data to a MAX7219 register write.
module max7219_cmd_rom #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter logic [7:0]  DECODE_MODE = 8'hFF
) (
    input  logic [3:0]  i_index,
    input  logic [31:0] i_digits,
    input  logic [7:0]  i_dp,
    input  logic [3:0]  i_intensity,
    output logic [3:0]  o_addr,
    output logic [7:0]  o_data
);
    import max7219_pkg::*;

    localparam logic [3:0] LAST_IDX   = last_cmd_idx(NUM_DIGITS);
    localparam logic [7:0] SCAN_LIMIT = 8'(NUM_DIGITS - 1);

    logic [2:0] digit_sel;

    always_comb begin
        digit_sel = 3'(i_index - CMD_IDX_FIRST_DIGIT);
        o_addr    = ADDR_NOOP;
        o_data    = '0;
        if (i_index >= CMD_IDX_FIRST_DIGIT && i_index <= LAST_IDX) begin
            o_addr = ADDR_DIGIT0 + 4'(digit_sel);
            o_data = {i_dp[digit_sel], 3'b000, i_digits[{digit_sel, 2'b00} +: 4]};
        end else begin
            case (i_index)
                4'd0: begin o_addr = ADDR_SHUTDOWN;   o_data = 8'h01;              end
                4'd1: begin o_addr = ADDR_TEST;       o_data = 8'h00;              end
                4'd2: begin o_addr = ADDR_SCAN_LIMIT; o_data = SCAN_LIMIT;         end
                4'd3: begin o_addr = ADDR_DECODE;     o_data = DECODE_MODE;        end
                4'd4: begin o_addr = ADDR_INTENSITY;  o_data = {4'h0, i_intensity}; end
                default: begin end
            endcase
        end
    end

endmodule

// File: rtl/max7219_sequencer.sv
// MAX7219 command sequencer: power-up init, digit refresh and intensity updates
// issued one register write at a time through a strobe/busy SPI writer handshake.
module max7219_sequencer #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter logic [7:0]  DECODE_MODE = 8'hFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_refresh_stb,
    input  logic [31:0] i_digits,
    input  logic [7:0]  i_dp,
    input  logic [3:0]  i_intensity,
    output logic        o_stb,
    input  logic        i_busy,
    output logic [3:0]  o_addr,
    output logic [7:0]  o_data,
    output logic        o_init_done,
    output logic        o_busy
);
    import max7219_pkg::*;

    localparam logic [3:0] LAST_IDX = last_cmd_idx(NUM_DIGITS);

    seq_state_t  state;
    logic [3:0]  cmd_idx;
    logic [3:0]  end_idx;
    logic        init_pending;
    logic        refresh_pending;
    logic [3:0]  last_intensity;
    logic [31:0] snap_digits;
    logic [7:0]  snap_dp;
    logic [3:0]  snap_intensity;
    logic [3:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        intensity_change;
    logic        digits_request;

    assign intensity_change = (i_intensity != last_intensity);
    assign digits_request   = refresh_pending | i_refresh_stb;

    max7219_cmd_rom #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DECODE_MODE (DECODE_MODE)
    ) u_cmd_rom (
        .i_index     (cmd_idx),
        .i_digits    (snap_digits),
        .i_dp        (snap_dp),
        .i_intensity (snap_intensity),
        .o_addr      (rom_addr),
        .o_data      (rom_data)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= ST_IDLE;
            cmd_idx         <= '0;
            end_idx         <= '0;
            init_pending    <= 1'b1;
            refresh_pending <= 1'b0;
            last_intensity  <= '0;
            snap_digits     <= '0;
            snap_dp         <= '0;
            snap_intensity  <= '0;
            o_stb           <= 1'b0;
            o_addr          <= '0;
            o_data          <= '0;
            o_init_done     <= 1'b0;
            o_busy          <= 1'b1;
        end else begin
            o_stb <= 1'b0;
            // Strobes that cannot start a sequence right now collapse into one pending refresh.
            if (i_refresh_stb && (state != ST_IDLE || init_pending))
                refresh_pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (init_pending) begin
                        init_pending   <= 1'b0;
                        cmd_idx        <= CMD_IDX_FIRST;
                        end_idx        <= LAST_IDX;
                        snap_digits    <= i_digits;
                        snap_dp        <= i_dp;
                        snap_intensity <= i_intensity;
                        o_busy         <= 1'b1;
                        state          <= ST_SEND;
                    end else if (intensity_change || digits_request) begin
                        cmd_idx        <= intensity_change ? CMD_IDX_INTENSITY : CMD_IDX_FIRST_DIGIT;
                        end_idx        <= digits_request ? LAST_IDX : CMD_IDX_INTENSITY;
                        snap_digits    <= i_digits;
                        snap_dp        <= i_dp;
                        snap_intensity <= i_intensity;
                        if (digits_request)
                            refresh_pending <= 1'b0;
                        o_busy         <= 1'b1;
                        state          <= ST_SEND;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end

                ST_SEND: begin
                    if (!i_busy) begin
                        o_stb  <= 1'b1;
                        o_addr <= rom_addr;
                        o_data <= rom_data;
                        if (cmd_idx == CMD_IDX_INTENSITY)
                            last_intensity <= snap_intensity;
                        state  <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (i_busy)
                        state <= ST_WAIT_DONE;
                end

                ST_WAIT_DONE: begin
                    if (!i_busy) begin
                        if (cmd_idx >= end_idx) begin
                            o_init_done <= 1'b1;
                            o_busy      <= digits_request | intensity_change;
                            state       <= ST_IDLE;
                        end else begin
                            cmd_idx <= cmd_idx + 4'd1;
                            state   <= ST_SEND;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
